// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_adder_pkg;

    localparam int SA_N = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sa_state_e;

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder cell: combinational sum and carry of two bits plus a carry-in.
module Full_Adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: one bit pair per clock through a single full-adder cell,
// LSB first, with a registered carry; sum/cout hold until the next accepted start.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int N = SA_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    sa_state_e     state_q, state_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [N-1:0]  sum_q, sum_d;
    logic          carry_q, carry_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fa_s, fa_c;

    Full_Adder u_fa (
        .a_i (a_q[0]),
        .b_i (b_q[0]),
        .c_i (carry_q),
        .s_o (fa_s),
        .c_o (fa_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    sum_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Each sum bit enters at the MSB so that after N shifts bit 0 lands at sum[0].
                sum_d   = {fa_s, sum_q[N-1:1]};
                a_d     = {1'b0, a_q[N-1:1]};
                b_d     = {1'b0, b_q[N-1:1]};
                carry_d = fa_c;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at N=8 (directed) and N=4 (exhaustive).
module tb_serial_adder;

    typedef struct {
        logic [8:0] res;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;

    logic       start8 = 1'b0, cin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;

    logic       start4 = 1'b0, cin4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       busy4, done4, cout4;
    logic [3:0] sum4;

    exp_t q8[$];
    exp_t q4[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_adder #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.N(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (done8) begin
            if (q8.size() == 0) begin
                chk("n8_unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = q8.pop_front();
                chk("n8_result", int'({cout8, sum8}), int'(e.res));
                chk("n8_done_cycle", cyc, e.cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (done4) begin
            if (q4.size() == 0) begin
                chk("n4_unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = q4.pop_front();
                chk("n4_result", int'({cout4, sum4}), int'(e.res));
                chk("n4_done_cycle", cyc, e.cyc);
            end
        end
    end

    // Start asserted for one cycle; the cycle it is high is 'cyc' right after the edge.
    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c,
                          input bit push, input logic [8:0] exp_res);
        @(posedge clk); #1;
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        if (push) q8.push_back('{res: exp_res, cyc: cyc + 9});
        @(posedge clk); #1;
        start8 = 1'b0;
    endtask

    task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic c);
        @(posedge clk); #1;
        a4 = a; b4 = b; cin4 = c; start4 = 1'b1;
        q4.push_back('{res: 9'({1'b0, a} + {1'b0, b} + {4'b0, c}), cyc: cyc + 5});
        @(posedge clk); #1;
        start4 = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    initial begin
        int bc;
        #12;
        chk("rst_sum", int'(sum8), 0);
        chk("rst_cout", int'(cout8), 0);
        chk("rst_busy", int'(busy8), 0);
        chk("rst_done", int'(done8), 0);
        @(negedge clk); rst = 1'b0;

        // 3 + 5 with busy width check
        issue8(8'd3, 8'd5, 1'b0, 1'b1, 9'd8);
        bc = 0;
        repeat (9) begin
            @(negedge clk);
            if (busy8) bc++;
        end
        chk("busy_cycles", bc, 8);
        repeat (2) @(posedge clk);

        // 255 + 1, hold through IDLE, then 0 + 0 + 1
        issue8(8'd255, 8'd1, 1'b0, 1'b1, 9'h100);
        repeat (11) @(negedge clk);
        chk("hold_sum", int'(sum8), 0);
        chk("hold_cout", int'(cout8), 1);
        issue8(8'd0, 8'd0, 1'b1, 1'b1, 9'd1);
        repeat (11) @(posedge clk);

        // extra start mid-SHIFT is ignored
        issue8(8'h5A, 8'h3C, 1'b0, 1'b1, 9'h096);
        repeat (2) @(posedge clk); #1;
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (10) @(posedge clk);

        // start held high for 30 cycles: accepted every N+2 cycles
        @(posedge clk); #1;
        a8 = 8'h81; b8 = 8'h7F; cin8 = 1'b1; start8 = 1'b1;
        q8.push_back('{res: 9'h101, cyc: cyc + 9});
        q8.push_back('{res: 9'h101, cyc: cyc + 19});
        q8.push_back('{res: 9'h101, cyc: cyc + 29});
        repeat (30) @(posedge clk);
        #1 start8 = 1'b0;
        repeat (5) @(posedge clk);

        // async reset during SHIFT cycle 4; in-flight op must vanish
        issue8(8'd77, 8'd88, 1'b1, 1'b0, 9'd0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_sum", int'(sum8), 0);
        chk("arst_cout", int'(cout8), 0);
        chk("arst_busy", int'(busy8), 0);
        chk("arst_done", int'(done8), 0);
        @(negedge clk); rst = 1'b0;
        repeat (2) @(posedge clk);
        issue8(8'd100, 8'd100, 1'b0, 1'b1, 9'd200);
        repeat (12) @(posedge clk);

        // N=4 exhaustive
        for (int ia = 0; ia < 16; ia++)
            for (int ib = 0; ib < 16; ib++)
                for (int ic = 0; ic < 2; ic++)
                    issue4(4'(ia), 4'(ib), 1'(ic));

        repeat (20) @(posedge clk);
        chk("n8_missing_done", q8.size(), 0);
        chk("n4_missing_done", q4.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial N-bit adder built around the existing one-bit full adder: it accepts two N-bit operands and a carry-in on a start pulse, then processes one bit pair per clock, LSB first, with a registered carry. After N shift cycles it presents the N-bit sum and carry-out with a one-cycle done pulse. It sits directly downstream of the full-adder cell and is its first sequential consumer: the cell supplies the per-bit S/C, and this block sequences operands through it.

## Interface
- N, default 8: operand/sum width in bits; N ≥ 2.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  N  operand A; captured on accepted start.
- b  input  N  operand B; captured on accepted start.
- cin  input  1  carry-in; captured on accepted start.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse; sum/cout valid.
- sum  output  N  result; holds until the next accepted start.
- cout  output  1  final carry; holds like sum.

## Operation
- States:
  - IDLE: start=1 → load a_sr=a, b_sr=b, carry=cin, cnt=0, clear sum_sr → SHIFT.
  - SHIFT: full adder on (a_sr[0], b_sr[0], carry). S shifts into sum_sr[N-1]. sum_sr, a_sr and b_sr shift right by one. carry←C, cnt←cnt+1. When cnt==N-1 on this edge → DONE.
  - DONE: done=1 for exactly one cycle → IDLE.
- cnt width: $clog2(N); no wrap, because the exit happens at N-1.
- sum = sum_sr; cout = carry register. Both hold their value in IDLE and DONE.
- Result is (a+b+cin) mod 2^N; cout = bit N of the full-width sum.
- start in SHIFT or DONE: ignored, with no queueing. Operands and cin may change freely once captured.
- start held high continuously: a new operation is accepted on each return to IDLE.
- Reset, at any time including mid-operation: state=IDLE, busy=0, done=0, sum=0, cout=0, all internal registers 0. An operation in flight is lost.

## Timing
- Edge E0 samples start=1 in IDLE; SHIFT then occupies edges E1..EN.
- Edge EN enters DONE; done is high in the cycle after EN.
- Latency: done asserts N+1 cycles after the cycle in which start was high.
- Throughput: one operation per N+2 cycles, including the mandatory IDLE cycle after DONE.
- busy rises the cycle after E0 and falls at EN.
- sum/cout change only in SHIFT. Intermediate sum values during SHIFT are don't-care to consumers; only the DONE cycle and later are valid.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package/include serial_adder_pkg:
  - state encodings IDLE=2'd0, SHIFT=2'd1, DONE=2'd2, with 2'd3 → IDLE on the default branch.
  - default width constant SA_N=8.
- One sub-module: the existing Full_Adder cell, instantiated once for the per-bit S/C.
- Remaining logic stays flat in serial_adder: the FSM, the a/b/sum shift registers, the carry flop and the counter.

## Test plan
- N=8: a=3, b=5, cin=0, start pulse → done exactly 9 cycles later; sum=8, cout=0; busy high for 8 cycles.
- N=8: a=255, b=1, cin=0 → sum=0, cout=1. Then a=0, b=0, cin=1 → sum=1, cout=0. sum/cout hold through IDLE between the two operations.
- N=8: a=0x5A, b=0x3C; start pulsed again mid-SHIFT with different operands → the extra start is ignored, single done, sum=0x96, cout=0.
- start held high for 30 cycles with fixed operands → done pulses every 10 cycles (N+2), each one cycle wide.
- Reset asserted asynchronously at SHIFT cycle 4 → outputs 0 immediately, state IDLE. A new start after reset deasserts completes correctly: 100+100 → sum=200, cout=0.
- N=4 exhaustive: all a, b, cin (512 cases) against the reference a+b+cin → {cout, sum} matches, with done latency N+1 on every case.
